// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared state encodings and sizing for the instruction memory loader
package inst_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BYTE = 2'd2,
    S_DONE = 2'd3
  } loader_state_t;

  localparam int MEM_BYTES         = 256;
  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_MAX_WORDS = MEM_BYTES / BYTES_PER_WORD;

endpackage

// File: rtl/inst_mem_loader_word_byte_ser.sv
// rtl/inst_mem_loader_word_byte_ser.sv - 32-bit word to big-endian byte serializer
module word_byte_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_advance,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;

  // Load a fresh word, then shift one byte per step; stop on byte 3 so the
  // last byte stays on the output after the word is finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (i_advance && (r_cnt != 2'd3)) begin
      r_shift <= {r_shift[23:0], 8'h00};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_byte = r_shift[31:24];
  assign o_last = (r_cnt == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - stream-to-byte-write program loader; optional LOADER_CHECKSUM_EN adds a word checksum
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        word_count,
  input  logic [31:0]       in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              We,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

  loader_state_t     r_state, w_next;
  logic [7:0]        r_count, r_word_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_err;
  logic              w_start, w_too_many, w_accept, w_in_byte, w_ser_last;
  logic [7:0]        w_word_idx_nxt, w_ser_byte;

  assign w_start        = (r_state == S_IDLE) && start;
  assign w_too_many     = {1'b0, word_count} > MAX_W9;
  assign w_accept       = (r_state == S_WAIT) && in_valid;
  assign w_in_byte      = (r_state == S_BYTE);
  assign w_word_idx_nxt = r_word_idx + 8'd1;

  word_byte_ser u_ser (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_word   (in_word),
    .i_advance(w_in_byte),
    .o_byte   (w_ser_byte),
    .o_last   (w_ser_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: empty or oversized sessions go straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = ((word_count == 8'd0) || w_too_many) ? S_DONE : S_WAIT;
      S_WAIT: if (in_valid) w_next = S_BYTE;
      S_BYTE: if (w_ser_last) w_next = (w_word_idx_nxt == r_count) ? S_DONE : S_WAIT;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Session bookkeeping: word count, word index and the sticky reject flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_word_idx <= '0;
      r_err      <= 1'b0;
    end else if (w_start) begin
      r_count    <= word_count;
      r_word_idx <= '0;
      r_err      <= w_too_many;
    end else if (w_in_byte && w_ser_last) begin
      r_word_idx <= w_word_idx_nxt;
    end
  end

  // Registered write strobe and byte address; both hold once a word is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_we   <= 1'b1;
      r_addr <= BASE_ADDR + ADDR_W'({r_word_idx, 2'b00});
    end else if (w_in_byte) begin
      if (w_ser_last) r_we   <= 1'b0;
      else            r_addr <= r_addr + ADDR_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running sum of accepted words, restarted by every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_checksum <= '0;
    else if (w_start && !w_too_many) r_checksum <= '0;
    else if (w_accept)            r_checksum <= r_checksum + in_word;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready      = (r_state == S_WAIT);
  assign busy          = (r_state == S_WAIT) || (r_state == S_BYTE);
  assign done          = (r_state == S_DONE);
  assign err           = r_err;
  assign We            = r_we;
  assign write_address = r_addr;
  assign write_data    = w_ser_byte;

endmodule
